mmio_bridge: RTL and testbench

Initiator side of the peripheral request bus: accepts single-beat MMIO loads and stores from the RV32 core data port and drives the `req_*` handshake that the CLINT and other local peripherals respond to. Sits between the core's data-memory arbiter and the peripheral fabric. Its duties:
- Decodes the peripheral window.
- Checks alignment.
- Right-justifies store data.
- Sign- or zero-extends load data.
- Converts a stalled peripheral into an error response through a timeout.

---
 rtl/mmio_pkg.sv | 48 ++++
 rtl/mmio_load_ext.sv | 23 ++
 rtl/mmio_bridge.sv | 146 ++++++++++++++
 tb/tb_mmio_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and encodings for the MMIO peripheral bridge.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // RISC-V load/store funct3 encodings.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Peripheral transfer size encodings.
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  // Reserved funct3 values, plus unsigned variants that only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (we && ((f3 == LBU) || (f3 == LHU)));
  endfunction

  // Halves need bit 0 clear, words need bits 1:0 clear.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == SZ_H[1:0]) && a[0]) ||
           ((f3[1:0] == SZ_W[1:0]) && (a != 2'b00));
  endfunction

  // Keep only the bytes the store actually writes; the rest go out as zero.
  function automatic logic [31:0] store_justify(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mmio_load_ext.sv
// Combinational sign/zero extension of right-justified peripheral load data.
module mmio_load_ext
  import mmio_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  // Select the extension rule from the load funct3.
  always_comb begin
    // NOTE: the output is assigned before the case so no funct3 value can infer a latch.
    data_o = data_i;
    case (funct3_i)
      LB:      data_o = {{24{data_i[7]}}, data_i[7:0]};
      LH:      data_o = {{16{data_i[15]}}, data_i[15:0]};
      LBU:     data_o = {24'b0, data_i[7:0]};
      LHU:     data_o = {16'b0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// Core-side MMIO initiator: window decode, alignment/funct3 checks, timed
// peripheral handshake and extended single-cycle response.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          WINDOW_BITS = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_valid,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic                   cpu_we,
  input  logic [2:0]             cpu_funct3,
  output logic                   cpu_ready,
  output logic                   cpu_rsp_valid,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_err,
  output logic                   req_valid,
  output logic [WINDOW_BITS-1:0] req_addr,
  output logic [63:0]            req_wdata,
  output logic                   req_we,
  output logic [2:0]             req_size,
  input  logic                   req_ready,
  input  logic [63:0]            req_rdata
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       ext_data;
  logic              window_hit;
  logic              unused_rdata_hi;

  // Upper half of the peripheral read bus is never used; 64-bit registers
  // are read as two word accesses.
  assign unused_rdata_hi = ^req_rdata[63:32];

  mmio_load_ext u_load_ext (
    .data_i   (req_rdata[31:0]),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  assign window_hit = (addr_q[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);

  // Next-state and datapath update for the IDLE/CHECK/ISSUE/RESP sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_we ? store_justify(cpu_funct3, cpu_wdata) : 32'b0;
          we_d     = cpu_we;
          funct3_d = cpu_funct3;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!window_hit || misaligned(funct3_q, addr_q[1:0]) || f3_illegal(funct3_q, we_q)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_MAX) begin
          // Peripheral stalled too long: abandon the request and fault.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (req_ready) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'b0 : ext_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Response fields are only non-zero during the pulse itself.
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop load its pre-edge value.
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cpu_ready     = (state_q == IDLE);
  assign cpu_rsp_valid = (state_q == RESP);
  assign cpu_rdata     = rdata_q;
  assign cpu_err       = err_q;
  assign req_valid     = (state_q == ISSUE);
  assign req_addr      = addr_q[WINDOW_BITS-1:0];
  assign req_wdata     = {32'b0, wdata_q};
  assign req_we        = we_q;
  assign req_size      = {1'b0, funct3_q[1:0]};

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge with a programmable-latency peripheral.
module tb_mmio_bridge;
  import mmio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic        cpu_ready;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_size;
  logic        req_ready;
  logic [63:0] req_rdata;

  mmio_bridge #(
    .BASE_ADDR   (32'h0200_0000),
    .WINDOW_BITS (16),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_valid     (cpu_valid),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_funct3    (cpu_funct3),
    .cpu_ready     (cpu_ready),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rdata     (cpu_rdata),
    .cpu_err       (cpu_err),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_ready     (req_ready),
    .req_rdata     (req_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {err, rdata} per access, pushed at issue and popped at response.
  logic [32:0] exp_q[$];

  // Responder controls (written only by the main sequence).
  int          resp_wait  = 0;   // ISSUE cycles before ready; -1 = never
  logic [63:0] resp_data  = '0;
  logic        late_pulse = 1'b0;

  // Observations (written only by the monitor).
  int          cyc        = 0;
  int          rv_total   = 0;
  int          rsp_total  = 0;
  int          rsp_cyc    = 0;
  int          viol_total = 0;
  logic [31:0] rsp_rdata  = '0;
  logic        rsp_err    = 1'b0;
  logic        prev_rv    = 1'b0;
  logic [15:0] seen_addr  = '0;
  logic [63:0] seen_wdata = '0;
  logic        seen_we    = 1'b0;
  logic [2:0]  seen_size  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: request fields, stability, busy flag and responses.
  always @(negedge clk) begin
    if (req_valid) begin
      rv_total <= rv_total + 1;
      if (!prev_rv) begin
        seen_addr  <= req_addr;
        seen_wdata <= req_wdata;
        seen_we    <= req_we;
        seen_size  <= req_size;
      end else if (req_addr !== seen_addr || req_wdata !== seen_wdata ||
                   req_we !== seen_we || req_size !== seen_size || cpu_ready !== 1'b0) begin
        viol_total <= viol_total + 1;
      end
    end
    prev_rv <= req_valid;
    if (cpu_rsp_valid) begin
      rsp_total <= rsp_total + 1;
      rsp_cyc   <= cyc;
      rsp_rdata <= cpu_rdata;
      rsp_err   <= cpu_err;
    end
  end

  // Peripheral model: ready after resp_wait ISSUE cycles, or a forced late pulse.
  initial begin
    int wcnt;
    logic ready_now;
    wcnt      = 0;
    req_ready = 1'b0;
    req_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (req_valid) begin
        ready_now = (resp_wait >= 0) && (wcnt == resp_wait);
        wcnt++;
      end else begin
        ready_now = 1'b0;
        wcnt = 0;
      end
      req_ready = ready_now || late_pulse;
      req_rdata = resp_data;
    end
  end

  // One complete access: drive, score the response, check latency and request fields.
  task automatic do_access(input string name, input logic [31:0] a, input logic [31:0] wd,
                           input logic we, input logic [2:0] f3, input int wait_cyc,
                           input logic [63:0] rd, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat, input int exp_rv,
                           input logic [15:0] exp_addr, input logic [63:0] exp_wdata,
                           input logic [2:0] exp_size);
    int t, start, rv0, rsp0, viol0;
    logic [32:0] want;
    resp_wait = wait_cyc;
    resp_data = rd;
    t = 0;
    while (cpu_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    checks++;
    if (cpu_ready !== 1'b1) begin
      $display("FAIL %s idle cpu_ready got %b want 1", name, cpu_ready);
      errors++;
    end
    rv0   = rv_total;
    rsp0  = rsp_total;
    viol0 = viol_total;
    exp_q.push_back({exp_err, exp_rdata});
    cpu_addr   = a;
    cpu_wdata  = wd;
    cpu_we     = we;
    cpu_funct3 = f3;
    cpu_valid  = 1'b1;
    start      = cyc;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    t = 0;
    while (rsp_total == rsp0 && t < 100) begin @(posedge clk); #1; t++; end
    want = exp_q.pop_front();
    checks++;
    if (rsp_total == rsp0) begin
      $display("FAIL %s response got none want one within 100 cycles", name);
      errors++;
    end else begin
      checks++;
      if (rsp_rdata !== want[31:0]) begin
        $display("FAIL %s rdata got %h want %h", name, rsp_rdata, want[31:0]);
        errors++;
      end
      checks++;
      if (rsp_err !== want[32]) begin
        $display("FAIL %s err got %b want %b", name, rsp_err, want[32]);
        errors++;
      end
      // Latency counts the accept cycle through the response cycle inclusive.
      checks++;
      if (rsp_cyc - start + 1 != exp_lat) begin
        $display("FAIL %s latency got %0d want %0d", name, rsp_cyc - start + 1, exp_lat);
        errors++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_total != rsp0 + 1) begin
      $display("FAIL %s rsp pulses got %0d want 1", name, rsp_total - rsp0);
      errors++;
    end
    checks++;
    if (rv_total - rv0 != exp_rv) begin
      $display("FAIL %s req_valid cycles got %0d want %0d", name, rv_total - rv0, exp_rv);
      errors++;
    end
    checks++;
    if (viol_total != viol0) begin
      $display("FAIL %s held fields/busy violations got %0d want 0", name, viol_total - viol0);
      errors++;
    end
    if (exp_rv > 0) begin
      checks++;
      if (seen_addr !== exp_addr || seen_wdata !== exp_wdata || seen_we !== we ||
          seen_size !== exp_size) begin
        $display("FAIL %s req fields got addr=%h wdata=%h we=%b size=%0d want addr=%h wdata=%h we=%b size=%0d",
                 name, seen_addr, seen_wdata, seen_we, seen_size, exp_addr, exp_wdata, we, exp_size);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    cpu_valid  = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_we     = 1'b0;
    cpu_funct3 = '0;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin
      $display("FAIL reset_cpu got ready=%b rsp=%b rdata=%h err=%b want 1 0 0 0",
               cpu_ready, cpu_rsp_valid, cpu_rdata, cpu_err);
      errors++;
    end
    checks++;
    if (req_valid !== 1'b0 || req_addr !== 16'h0 || req_wdata !== 64'h0 ||
        req_we !== 1'b0 || req_size !== 3'd0) begin
      $display("FAIL reset_req got valid=%b addr=%h wdata=%h we=%b size=%0d want all 0",
               req_valid, req_addr, req_wdata, req_we, req_size);
      errors++;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      $display("FAIL reset_release cpu_ready got %b want 1", cpu_ready);
      errors++;
    end
  endtask

  task automatic test_passthrough();
    do_access("lw_wait3", 32'h0200_BFF8, 32'h0, 1'b0, LW, 3, 64'h0000_0000_8000_0001,
              32'h8000_0001, 1'b0, 7, 4, 16'hBFF8, 64'h0, SZ_W);
    do_access("lw_hi_ignored", 32'h0200_0100, 32'h0, 1'b0, LW, 1, 64'hDEAD_BEEF_1234_5678,
              32'h1234_5678, 1'b0, 5, 2, 16'h0100, 64'h0, SZ_W);
  endtask

  task automatic test_stores();
    do_access("sw", 32'h0200_4004, 32'h9ABC_DEF0, 1'b1, SW, 0, 64'hFFFF_FFFF_FFFF_FFFF,
              32'h0, 1'b0, 4, 1, 16'h4004, 64'h0000_0000_9ABC_DEF0, SZ_W);
    do_access("sb", 32'h0200_0000, 32'h0000_00A5, 1'b1, SB, 0, 64'h0,
              32'h0, 1'b0, 4, 1, 16'h0000, 64'h0000_0000_0000_00A5, SZ_B);
    do_access("sh", 32'h0200_0002, 32'h0000_BEEF, 1'b1, SH, 2, 64'h0,
              32'h0, 1'b0, 6, 3, 16'h0002, 64'h0000_0000_0000_BEEF, SZ_H);
  endtask

  task automatic test_extension();
    do_access("lb", 32'h0200_0003, 32'h0, 1'b0, LB, 0, 64'h80,
              32'hFFFF_FF80, 1'b0, 4, 1, 16'h0003, 64'h0, SZ_B);
    do_access("lbu", 32'h0200_0003, 32'h0, 1'b0, LBU, 0, 64'h80,
              32'h0000_0080, 1'b0, 4, 1, 16'h0003, 64'h0, SZ_B);
    do_access("lh", 32'h0200_0006, 32'h0, 1'b0, LH, 0, 64'h8001,
              32'hFFFF_8001, 1'b0, 4, 1, 16'h0006, 64'h0, SZ_H);
    do_access("lhu", 32'h0200_0006, 32'h0, 1'b0, LHU, 1, 64'h8001,
              32'h0000_8001, 1'b0, 5, 2, 16'h0006, 64'h0, SZ_H);
  endtask

  task automatic test_reject();
    do_access("rej_window", 32'h0300_0000, 32'h0, 1'b0, LW, 0, 64'h1,
              32'h0, 1'b1, 3, 0, 16'h0, 64'h0, SZ_W);
    do_access("rej_lw_align", 32'h0200_4002, 32'h0, 1'b0, LW, 0, 64'h1,
              32'h0, 1'b1, 3, 0, 16'h0, 64'h0, SZ_W);
    do_access("rej_lh_align", 32'h0200_0001, 32'h0, 1'b0, LH, 0, 64'h1,
              32'h0, 1'b1, 3, 0, 16'h0, 64'h0, SZ_H);
    do_access("rej_f3_011", 32'h0200_0000, 32'h0, 1'b0, 3'b011, 0, 64'h1,
              32'h0, 1'b1, 3, 0, 16'h0, 64'h0, SZ_D);
    do_access("rej_store_f3_100", 32'h0200_0000, 32'h55, 1'b1, 3'b100, 0, 64'h1,
              32'h0, 1'b1, 3, 0, 16'h0, 64'h0, SZ_B);
  endtask

  task automatic test_timeout();
    int rsp0;
    // TIMEOUT = 8: nine ISSUE cycles, so 4 + 8 cycles end to end.
    do_access("timeout", 32'h0200_0040, 32'h0, 1'b0, LW, -1, 64'h1234,
              32'h0, 1'b1, 12, 9, 16'h0040, 64'h0, SZ_W);
    rsp0 = rsp_total;
    late_pulse = 1'b1;
    @(posedge clk); #1;
    late_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_total != rsp0 || cpu_ready !== 1'b1) begin
      $display("FAIL late_ready got rsp=%0d ready=%b want rsp=0 ready=1",
               rsp_total - rsp0, cpu_ready);
      errors++;
    end
    do_access("after_timeout", 32'h0200_0044, 32'h0, 1'b0, LW, 0, 64'h0000_0000_CAFE_F00D,
              32'hCAFE_F00D, 1'b0, 4, 1, 16'h0044, 64'h0, SZ_W);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      logic [31:0] a;
      int          w;
      d = $urandom;
      w = $urandom_range(0, 3);
      a = 32'h0200_0000 + (32'($urandom_range(0, 16383)) << 2);
      do_access("b2b_lw", a, 32'h0, 1'b0, LW, w, {32'hFFFF_0000, d},
                d, 1'b0, 4 + w, 1 + w, a[15:0], 64'h0, SZ_W);
    end
  endtask

  task automatic test_reset_issue();
    int t, rsp0;
    resp_wait = -1;
    rsp0 = rsp_total;
    @(posedge clk); #1;
    cpu_addr   = 32'h0200_0010;
    cpu_wdata  = 32'h0;
    cpu_we     = 1'b0;
    cpu_funct3 = LW;
    cpu_valid  = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    t = 0;
    while (req_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (req_valid !== 1'b1) begin
      $display("FAIL rst_issue_enter req_valid got %b want 1", req_valid);
      errors++;
    end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || cpu_ready !== 1'b1) begin
      $display("FAIL rst_issue_async got req_valid=%b cpu_ready=%b want 0 1", req_valid, cpu_ready);
      errors++;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_total != rsp0 || cpu_ready !== 1'b1) begin
      $display("FAIL rst_issue_after got rsp=%0d ready=%b want rsp=0 ready=1",
               rsp_total - rsp0, cpu_ready);
      errors++;
    end
    do_access("after_reset", 32'h0200_0020, 32'h0, 1'b0, LHU, 0, 64'hFFFF_FFFF_0000_7FFE,
              32'h0000_7FFE, 1'b0, 4, 1, 16'h0020, 64'h0, SZ_H);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_stores();
    test_extension();
    test_reject();
    test_timeout();
    test_back_to_back();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
